// File: rtl/spi_tx_pkg.sv
// Shared types and helpers for the SPI stream transmitter.
package spi_tx_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    // Word returned for an ID query ("SLA1").
    localparam logic [31:0] SLA1_ID = 32'h534C4131;

    // Leading edge: SPI clock leaves its idle level.
    function automatic logic lead_edge(input logic cpol, input logic prev, input logic cur);
        return (prev == cpol) && (cur != cpol);
    endfunction

    // Trailing edge: SPI clock returns to its idle level.
    function automatic logic trail_edge(input logic cpol, input logic prev, input logic cur);
        return (prev != cpol) && (cur == cpol);
    endfunction

    // Edge on which a new bit is presented: trailing for CPHA=0, leading for CPHA=1.
    function automatic logic drive_edge(input logic cpol, input logic cpha,
                                        input logic prev, input logic cur);
        return cpha ? lead_edge(cpol, prev, cur) : trail_edge(cpol, prev, cur);
    endfunction

endpackage

// File: rtl/spi_tx_word_fifo.sv
// Synchronous word FIFO holding {byte-valid mask, data} entries.
// A pop and a push in the same cycle are both honoured even when full.
module spi_tx_word_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             extReset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Accept a pop only when data exists; a push needs space or a concurrent pop.
    always_comb begin
        pop_ok_s  = pop_i && (count_q != '0);
        push_ok_s = push_i && ((count_q != CW'(DEPTH)) || pop_ok_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/spi_stream_transmitter.sv
// SPI slave transmitter: queues byte-masked words and shifts them out
// MSB first, byte 0 first, in any CPOL/CPHA mode.
module spi_stream_transmitter #(
    parameter int BYTES      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                        clock,
    input  logic                        extReset,
    input  logic                        sclk,
    input  logic                        cs,
    input  logic                        send,
    input  logic [8*BYTES-1:0]          send_data,
    input  logic [BYTES-1:0]            send_valid,
    input  logic                        writeMeta,
    input  logic [7:0]                  meta_data,
    input  logic                        query_id,
    input  logic                        query_dataIn,
    input  logic [31:0]                 dataIn,
    output logic                        tx,
    output logic                        busy,
    output logic                        byteDone,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    import spi_tx_pkg::*;

    localparam int DATA_W  = 8 * BYTES;
    localparam int ENTRY_W = DATA_W + BYTES;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W   = $clog2(BYTES);

    // Synchronisers; sclk gets a third flop for edge detection.
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q;

    // Control and shift state.
    state_t            state_q;
    logic [DATA_W-1:0] word_q;
    logic [BYTES-1:0]  valid_q;
    logic [7:0]        shift_q;
    logic [2:0]        bits_q;
    logic              byte_done_q;
    logic              tx_q;
    logic              busy_q;
    logic              overflow_q;

    // Combinational helpers.
    logic               push_req_s;
    logic [ENTRY_W-1:0] push_entry_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] fifo_rdata_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               drive_s;
    logic               count_s;
    logic               sel_found_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic [7:0]         sel_byte_s;

    // Bring the asynchronous SPI pins into the clock domain.
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            sclk_meta_q <= CPOL;
            sclk_sync_q <= CPOL;
            sclk_prev_q <= CPOL;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= cs;
            cs_sync_q   <= cs_meta_q;
        end
    end

    // Push source select (send > query_id > query_dataIn) and FIFO pop request.
    always_comb begin
        push_req_s = send | query_id | query_dataIn;
        if (send) begin
            push_entry_s = {send_valid, send_data};
        end else if (query_id) begin
            push_entry_s = {{BYTES{1'b1}}, DATA_W'(SLA1_ID)};
        end else if (query_dataIn) begin
            push_entry_s = {{BYTES{1'b1}}, DATA_W'(dataIn)};
        end else begin
            push_entry_s = '0;
        end
        // A meta byte takes precedence over the queue in the same cycle.
        pop_s = (state_q == ST_IDLE) && !writeMeta && !fifo_empty_s;
    end

    // Edge events and lowest remaining valid byte of the current word.
    always_comb begin
        drive_s     = drive_edge(CPOL, CPHA, sclk_prev_q, sclk_sync_q);
        count_s     = trail_edge(CPOL, sclk_prev_q, sclk_sync_q);
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = BYTES - 1; i >= 0; i--) begin
            sel_found_s = valid_q[i] ? 1'b1 : sel_found_s;
            sel_idx_s   = valid_q[i] ? IDX_W'(i) : sel_idx_s;
        end
        sel_byte_s = word_q[8*sel_idx_s +: 8];
    end

    spi_tx_word_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .extReset (extReset),
        .push_i   (push_req_s),
        .wdata_i  (push_entry_s),
        .pop_i    (pop_s),
        .rdata_o  (fifo_rdata_s),
        .full_o   (fifo_full_s),
        .empty_o  (fifo_empty_s),
        .count_o  (fifo_count_s)
    );

    // Control FSM, byte shift engine and registered status outputs.
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            state_q     <= ST_INIT;
            word_q      <= '0;
            valid_q     <= '0;
            shift_q     <= 8'h00;
            bits_q      <= 3'd0;
            byte_done_q <= 1'b1;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    valid_q     <= '0;
                    bits_q      <= 3'd0;
                    byte_done_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (writeMeta) begin
                        shift_q     <= meta_data;
                        valid_q     <= '0;
                        bits_q      <= 3'd0;
                        byte_done_q <= 1'b0;
                        state_q     <= ST_SHIFT;
                    end else if (!fifo_empty_s) begin
                        word_q  <= fifo_rdata_s[DATA_W-1:0];
                        valid_q <= fifo_rdata_s[ENTRY_W-1:DATA_W];
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (sel_found_s) begin
                        shift_q            <= sel_byte_s;
                        valid_q[sel_idx_s] <= 1'b0;
                        bits_q             <= 3'd0;
                        byte_done_q        <= 1'b0;
                        state_q            <= ST_SHIFT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (byte_done_q) begin
                        state_q <= (|valid_q) ? ST_LOAD : ST_IDLE;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Shift engine: runs only with a byte in flight and cs asserted.
            if ((state_q == ST_SHIFT) && !byte_done_q) begin
                if (cs_sync_q) begin
                    // Host aborted: keep the byte, restart it from the MSB.
                    bits_q <= 3'd0;
                    tx_q   <= 1'b1;
                end else begin
                    if (!CPHA) begin
                        tx_q <= shift_q[3'd7 - bits_q];
                    end else if (drive_s) begin
                        tx_q <= shift_q[3'd7 - bits_q];
                    end else begin
                        tx_q <= tx_q;
                    end
                    if (count_s) begin
                        bits_q <= bits_q + 3'd1;
                        if (bits_q == 3'd7) begin
                            byte_done_q <= 1'b1;
                        end else begin
                            byte_done_q <= 1'b0;
                        end
                    end
                end
            end else begin
                tx_q <= 1'b1;
            end

            busy_q     <= (state_q == ST_LOAD) || (state_q == ST_SHIFT) ||
                          !fifo_empty_s || push_req_s || !byte_done_q;
            overflow_q <= overflow_q | (push_req_s && fifo_full_s && !pop_s);
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign byteDone   = byte_done_q;
    assign fifo_full  = fifo_full_s;
    assign fifo_count = fifo_count_s;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_spi_stream_transmitter.sv
// Directed plus randomized bench: a mode-0 instance and a mode-3 instance,
// host-side SPI tasks and a byte-queue reference model.
module tb_spi_stream_transmitter;

    localparam int HALF = 8;

    logic        clock = 1'b0;
    logic        extReset = 1'b1;

    // Mode 0 instance stimulus / observation
    logic        sclk0 = 1'b0, cs0 = 1'b1;
    logic        send = 1'b0, writeMeta = 1'b0, query_id = 1'b0, query_dataIn = 1'b0;
    logic [31:0] send_data = 32'h0, dataIn = 32'h0;
    logic [3:0]  send_valid = 4'h0;
    logic [7:0]  meta_data = 8'h00;
    logic        tx0, busy0, bd0, full0, ovf0;
    logic [3:0]  cnt0;

    // Mode 3 instance stimulus / observation
    logic        sclk3 = 1'b1, cs3 = 1'b1, qid3 = 1'b0;
    logic        tx3, busy3, bd3, full3, ovf3;
    logic [3:0]  cnt3;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q [$];

    always #5 clock = ~clock;

    spi_stream_transmitter #(.BYTES(4), .FIFO_DEPTH(8), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
        .clock(clock), .extReset(extReset), .sclk(sclk0), .cs(cs0),
        .send(send), .send_data(send_data), .send_valid(send_valid),
        .writeMeta(writeMeta), .meta_data(meta_data),
        .query_id(query_id), .query_dataIn(query_dataIn), .dataIn(dataIn),
        .tx(tx0), .busy(busy0), .byteDone(bd0), .fifo_full(full0),
        .fifo_count(cnt0), .overflow(ovf0)
    );

    spi_stream_transmitter #(.BYTES(4), .FIFO_DEPTH(8), .CPOL(1'b1), .CPHA(1'b1)) u_dut3 (
        .clock(clock), .extReset(extReset), .sclk(sclk3), .cs(cs3),
        .send(1'b0), .send_data(32'h0), .send_valid(4'h0),
        .writeMeta(1'b0), .meta_data(8'h00),
        .query_id(qid3), .query_dataIn(1'b0), .dataIn(32'h0),
        .tx(tx3), .busy(busy3), .byteDone(bd3), .fifo_full(full3),
        .fifo_count(cnt3), .overflow(ovf3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: a word contributes its enabled bytes, byte 0 first.
    task automatic model_push(input logic [31:0] d, input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) exp_q.push_back(d[8*i +: 8]);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] v);
        @(negedge clock);
        send = 1'b1; send_data = d; send_valid = v;
        @(negedge clock);
        send = 1'b0;
        model_push(d, v);
    endtask

    // Mode 0 host: sample before each rising edge, falling edge advances.
    task automatic spi0_byte(input int nbits, output logic [7:0] b);
        b = 8'h00;
        for (int k = 0; k < 300 && bd0 !== 1'b0; k++) @(negedge clock);
        check("mode0_load", {31'd0, bd0}, 32'd0);
        repeat (4) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            b = {b[6:0], tx0};
            sclk0 = 1'b1;
            repeat (HALF) @(negedge clock);
            sclk0 = 1'b0;
            repeat (HALF) @(negedge clock);
        end
    endtask

    // Mode 3 host: falling (leading) edge drives, sample before rising edge.
    task automatic spi3_byte(output logic [7:0] b);
        b = 8'h00;
        for (int k = 0; k < 300 && bd3 !== 1'b0; k++) @(negedge clock);
        check("mode3_load", {31'd0, bd3}, 32'd0);
        repeat (4) @(negedge clock);
        check("mode3_idle_tx", {31'd0, tx3}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            sclk3 = 1'b0;
            repeat (HALF) @(negedge clock);
            b = {b[6:0], tx3};
            sclk3 = 1'b1;
            repeat (HALF) @(negedge clock);
        end
    endtask

    task automatic drain0(input string tag);
        logic [7:0] b;
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            spi0_byte(8, b);
            e = exp_q.pop_front();
            check(tag, {24'd0, b}, {24'd0, e});
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] d;
        logic [3:0]  v;
        logic [31:0] id_word;

        // ---------------- reset state
        repeat (3) @(negedge clock);
        check("rst_tx", {31'd0, tx0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_bytedone", {31'd0, bd0}, 32'd1);
        check("rst_count", {28'd0, cnt0}, 32'd0);
        check("rst_full", {31'd0, full0}, 32'd0);
        check("rst_overflow", {31'd0, ovf0}, 32'd0);
        extReset = 1'b0;
        repeat (4) @(negedge clock);

        // ---------------- 1: mode 0 full word, latency
        cs0 = 1'b0;
        @(negedge clock);
        send = 1'b1; send_data = 32'hA1B2C3D4; send_valid = 4'hF;
        @(negedge clock);
        send = 1'b0;
        model_push(32'hA1B2C3D4, 4'hF);
        check("lat_busy", {31'd0, busy0}, 32'd1);
        check("lat_bd_n1", {31'd0, bd0}, 32'd1);
        @(negedge clock);
        check("lat_bd_n2", {31'd0, bd0}, 32'd1);
        @(negedge clock);
        check("lat_bd_n3", {31'd0, bd0}, 32'd0);
        drain0("t1_byte");
        repeat (10) @(negedge clock);
        check("t1_busy_after", {31'd0, busy0}, 32'd0);
        check("t1_tx_idle", {31'd0, tx0}, 32'd1);

        // ---------------- 2: masks, empty mask, priority, random words
        push_word(32'h11223344, 4'b0101);
        drain0("t2_masked");
        push_word(32'hDEADBEEF, 4'b0000);
        repeat (12) @(negedge clock);
        check("t2_empty_busy", {31'd0, busy0}, 32'd0);
        check("t2_empty_bd", {31'd0, bd0}, 32'd1);
        check("t2_empty_cnt", {28'd0, cnt0}, 32'd0);
        // send and query_id together: only the send word is queued
        @(negedge clock);
        send = 1'b1; query_id = 1'b1; send_data = 32'h00000077; send_valid = 4'b0001;
        @(negedge clock);
        send = 1'b0; query_id = 1'b0;
        model_push(32'h00000077, 4'b0001);
        drain0("t2_priority");
        repeat (12) @(negedge clock);
        check("t2_prio_busy", {31'd0, busy0}, 32'd0);
        // dataIn query
        d = $urandom;
        @(negedge clock);
        query_dataIn = 1'b1; dataIn = d;
        @(negedge clock);
        query_dataIn = 1'b0;
        model_push(d, 4'hF);
        drain0("t2_datain");
        for (int n = 0; n < 4; n++) begin
            d = $urandom;
            v = 4'($urandom_range(0, 15));
            push_word(d, v);
        end
        drain0("t2_random");
        repeat (12) @(negedge clock);
        check("t2_rand_busy", {31'd0, busy0}, 32'd0);

        // ---------------- 3: overflow with engine stalled by cs
        cs0 = 1'b1;
        repeat (4) @(negedge clock);
        @(negedge clock);
        for (int n = 0; n < 10; n++) begin
            d = $urandom;
            send = 1'b1; send_data = d; send_valid = 4'hF;
            if (n < 9) model_push(d, 4'hF);
            @(negedge clock);
        end
        send = 1'b0;
        repeat (3) @(negedge clock);
        check("t3_count", {28'd0, cnt0}, 32'd8);
        check("t3_full", {31'd0, full0}, 32'd1);
        check("t3_overflow", {31'd0, ovf0}, 32'd1);
        cs0 = 1'b0;
        drain0("t3_drain");
        repeat (12) @(negedge clock);
        check("t3_busy_after", {31'd0, busy0}, 32'd0);
        check("t3_ovf_sticky", {31'd0, ovf0}, 32'd1);

        // ---------------- 4: mode 3 ID query
        cs3 = 1'b0;
        @(negedge clock);
        qid3 = 1'b1;
        @(negedge clock);
        qid3 = 1'b0;
        id_word = 32'h534C4131;
        for (int i = 0; i < 4; i++) begin
            spi3_byte(b);
            check("t4_id_byte", {24'd0, b}, {24'd0, id_word[8*i +: 8]});
        end
        repeat (12) @(negedge clock);
        check("t4_busy_after", {31'd0, busy3}, 32'd0);
        check("t4_tx_idle", {31'd0, tx3}, 32'd1);

        // ---------------- 5: cs abort mid-byte, byte restarts
        @(negedge clock);
        writeMeta = 1'b1; meta_data = 8'hA5;
        @(negedge clock);
        writeMeta = 1'b0;
        spi0_byte(3, b);
        check("t5_partial", {29'd0, b[2:0]}, 32'd5);
        cs0 = 1'b1;
        repeat (10) @(negedge clock);
        check("t5_bd_held", {31'd0, bd0}, 32'd0);
        check("t5_tx_cs_high", {31'd0, tx0}, 32'd1);
        cs0 = 1'b0;
        spi0_byte(8, b);
        check("t5_resent", {24'd0, b}, 32'h000000A5);

        // ---------------- 6: reset mid-shift with 4 words queued
        repeat (12) @(negedge clock);
        push_word(32'h00000000, 4'hF);
        for (int n = 0; n < 4; n++) push_word($urandom, 4'hF);
        exp_q.delete();
        for (int k = 0; k < 300 && bd0 !== 1'b0; k++) @(negedge clock);
        repeat (4) @(negedge clock);
        check("t6_tx_zero_bit", {31'd0, tx0}, 32'd0);
        check("t6_queued", {28'd0, cnt0}, 32'd4);
        #2 extReset = 1'b1;
        #1;
        check("t6_rst_tx", {31'd0, tx0}, 32'd1);
        check("t6_rst_busy", {31'd0, busy0}, 32'd0);
        check("t6_rst_cnt", {28'd0, cnt0}, 32'd0);
        check("t6_rst_ovf", {31'd0, ovf0}, 32'd0);
        repeat (3) @(negedge clock);
        extReset = 1'b0;
        repeat (4) @(negedge clock);
        writeMeta = 1'b1; meta_data = 8'h5A;
        @(negedge clock);
        writeMeta = 1'b0;
        spi0_byte(8, b);
        check("t6_meta", {24'd0, b}, 32'h0000005A);
        repeat (12) @(negedge clock);
        check("t6_busy_after", {31'd0, busy0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
